router_reg: RTL and testbench

//  Datapath register stage of the 1x3 router, driven by the router FSM state strobes.
//  - Captures the header byte and stages every byte onto dout for the selected output FIFO.
//  - Holds a byte that arrives while the FIFO is full, and replays it after the full condition.
//  - Computes running XOR parity and compares it with the trailing parity byte.
//  - Returns parity_done and low_pkt_valid to the FSM; reports err to the output side.

---
 rtl/router_reg.sv | 119 +++++++++++
 tb/tb_router_reg.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 1x3 router.
// Stages bytes to the output FIFO and tracks packet parity.
module router_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] hdr;
  logic [DATA_WIDTH-1:0] full_byte;
  logic [DATA_WIDTH-1:0] int_par;
  logic [DATA_WIDTH-1:0] pkt_par;

  logic hdr_ok;
  logic par_byte;
  logic pd_set;

  assign hdr_ok   = detect_add & pkt_valid & (data_in[1:0] != 2'b11);
  assign par_byte = ld_state & ~pkt_valid;
  assign pd_set   = (par_byte & ~fifo_full)
                  | (laf_state & low_pkt_valid & ~parity_done);

  // Latch the header byte when it carries a usable address
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hdr <= '0;
    end else if (hdr_ok) begin
      hdr <= data_in;
    end
  end

  // Stage bytes to the FIFO; park a byte that meets a full FIFO
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout      <= '0;
      full_byte <= '0;
    end else if (lfd_state) begin
      dout <= hdr;
    end else if (ld_state && !fifo_full) begin
      dout <= data_in;
    end else if (ld_state) begin
      full_byte <= data_in;
    end else if (laf_state) begin
      dout <= full_byte;
    end else if (full_state) begin
      dout <= dout;
    end
  end

  // Running XOR over header and payload; parity byte never folded
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      int_par <= '0;
    end else if (detect_add) begin
      int_par <= '0;
    end else if (lfd_state) begin
      int_par <= int_par ^ hdr;
    end else if (ld_state && pkt_valid) begin
      int_par <= int_par ^ data_in;
    end
  end

  // Capture the trailing parity byte, full or not
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_par <= '0;
    end else if (par_byte) begin
      pkt_par <= data_in;
    end
  end

  // Flag the end of the source packet to the FSM
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      low_pkt_valid <= 1'b0;
    end else if (par_byte) begin
      low_pkt_valid <= 1'b1;
    end else if (rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end
  end

  // Parity byte has reached the FIFO
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      parity_done <= 1'b0;
    end else if (pd_set) begin
      parity_done <= 1'b1;
    end else if (detect_add) begin
      parity_done <= 1'b0;
    end
  end

  // Compare computed and received parity at packet check
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if (rst_int_reg) begin
      err <= (int_par != pkt_par);
    end else if (detect_add) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: directed and random packets for router_reg,
// checked against a packet-level parity/byte model.
module tb_router_reg;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [7:0] dout;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;

  router_reg #(.DATA_WIDTH(8)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .dout         (dout),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [7:0] pay [16];

  logic [7:0] m_hdr;
  logic [7:0] m_dout;
  logic [7:0] m_par;
  logic       m_pd;
  logic       m_lpv;
  logic       m_err;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic da, input logic lfd, input logic ld,
                      input logic laf, input logic fs, input logic ri,
                      input logic pv, input logic ff,
                      input logic [7:0] d);
    detect_add  = da;
    lfd_state   = lfd;
    ld_state    = ld;
    laf_state   = laf;
    full_state  = fs;
    rst_int_reg = ri;
    pkt_valid   = pv;
    fifo_full   = ff;
    data_in     = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic model_reset();
    m_hdr  = 8'h00;
    m_dout = 8'h00;
    m_par  = 8'h00;
    m_pd   = 1'b0;
    m_lpv  = 1'b0;
    m_err  = 1'b0;
  endtask

  // One packet: header, n payload bytes from pay[], then parity p.
  task automatic send_packet(input logic [7:0] h, input int n,
                             input logic [15:0] fmask,
                             input logic pfull, input logic [7:0] p);
    int k;
    step(1, 0, 0, 0, 0, 0, 1, 0, h);
    if (h[1:0] != 2'b11) m_hdr = h;
    m_par = 8'h00;
    m_pd  = 1'b0;
    m_err = 1'b0;
    chk("decode_dout", dout, m_dout);
    chk("decode_err", {7'd0, err}, {7'd0, m_err});
    chk("decode_pdone", {7'd0, parity_done}, {7'd0, m_pd});

    step(0, 1, 0, 0, 0, 0, 1, 0, pay[0]);
    m_dout = m_hdr;
    m_par  = m_par ^ m_hdr;
    chk("lfd_dout", dout, m_dout);

    for (int i = 0; i < n; i++) begin
      step(0, 0, 1, 0, 0, 0, 1, fmask[i], pay[i]);
      m_par = m_par ^ pay[i];
      if (!fmask[i]) m_dout = pay[i];
      chk("ld_dout", dout, m_dout);
      if (fmask[i]) begin
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++) begin
          step(0, 0, 0, 0, 1, 0, 1, 1, pay[i] ^ 8'hFF);
          chk("full_hold_dout", dout, m_dout);
        end
        step(0, 0, 0, 1, 0, 0, 1, 0, pay[i] ^ 8'h5A);
        m_dout = pay[i];
        chk("laf_dout", dout, m_dout);
        chk("laf_pdone", {7'd0, parity_done}, {7'd0, m_pd});
      end
    end

    step(0, 0, 1, 0, 0, 0, 0, pfull, p);
    m_lpv = 1'b1;
    if (!pfull) begin
      m_dout = p;
      m_pd   = 1'b1;
    end
    chk("par_dout", dout, m_dout);
    chk("par_lpv", {7'd0, low_pkt_valid}, {7'd0, m_lpv});
    chk("par_pdone", {7'd0, parity_done}, {7'd0, m_pd});
    if (pfull) begin
      step(0, 0, 0, 0, 1, 0, 0, 1, 8'hA5);
      chk("parfull_dout", dout, m_dout);
      step(0, 0, 0, 1, 0, 0, 0, 0, 8'h3C);
      m_dout = p;
      m_pd   = 1'b1;
      chk("parlaf_dout", dout, m_dout);
      chk("parlaf_pdone", {7'd0, parity_done}, {7'd0, m_pd});
    end

    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    m_err = (m_par != p);
    m_lpv = 1'b0;
    chk("check_err", {7'd0, err}, {7'd0, m_err});
    chk("check_lpv", {7'd0, low_pkt_valid}, {7'd0, m_lpv});

    idle();
    chk("idle_err", {7'd0, err}, {7'd0, m_err});
    chk("idle_pdone", {7'd0, parity_done}, {7'd0, m_pd});
  endtask

  initial begin
    logic [7:0]  h;
    logic [7:0]  x;
    logic [7:0]  p;
    logic [15:0] fm;
    int          n;

    resetn = 1'b0;
    model_reset();
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state = 0; rst_int_reg = 0; pkt_valid = 0; fifo_full = 0;
    data_in = 8'h00;
    #12;
    chk("rst_dout", dout, 8'h00);
    chk("rst_pdone", {7'd0, parity_done}, 8'h00);
    chk("rst_lpv", {7'd0, low_pkt_valid}, 8'h00);
    chk("rst_err", {7'd0, err}, 8'h00);
    @(negedge clock);
    resetn = 1'b1;
    idle();

    // Header 0D, payload 11 22 33, trailing parity 3D
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_packet(8'h0D, 3, 16'h0000, 1'b0, 8'h3D);
    // Same packet with trailing parity 3C
    send_packet(8'h0D, 3, 16'h0000, 1'b0, 8'h3C);
    // Trailing parity equal to header^payload XOR
    send_packet(8'h0D, 3, 16'h0000, 1'b0, 8'h0D);
    // FIFO full on byte 22, replayed in LOAD_AFTER_FULL
    send_packet(8'h0D, 3, 16'h0002, 1'b0, 8'h0D);
    // FIFO full on the parity byte
    send_packet(8'h0D, 3, 16'h0000, 1'b1, 8'h0D);

    // Invalid address 3 must not replace the header
    pay[0] = 8'h44;
    send_packet(8'h03, 1, 16'h0000, 1'b0, 8'h00);

    // Random packets
    for (int t = 0; t < 25; t++) begin
      h = 8'($urandom);
      h[1:0] = 2'($urandom_range(0, 2));
      n = $urandom_range(1, 8);
      x = h;
      fm = 16'h0000;
      for (int i = 0; i < n; i++) begin
        pay[i] = 8'($urandom);
        x = x ^ pay[i];
        fm[i] = ($urandom_range(0, 3) == 0);
      end
      p = ($urandom_range(0, 1) == 0) ? x
        : x ^ 8'($urandom_range(1, 255));
      send_packet(h, n, fm, 1'($urandom_range(0, 1)), p);
    end

    // Reset in the middle of a payload
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h9A);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h77);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h77);
    step(0, 0, 1, 0, 0, 0, 0, 1, 8'h55);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_dout", dout, 8'h00);
    chk("midrst_err", {7'd0, err}, 8'h00);
    chk("midrst_pdone", {7'd0, parity_done}, 8'h00);
    chk("midrst_lpv", {7'd0, low_pkt_valid}, 8'h00);
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    // Header and parity registers must also have cleared
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
    chk("postrst_hdr", dout, m_hdr);
    step(0, 0, 0, 1, 0, 0, 1, 0, 8'h00);
    chk("postrst_fullbyte", dout, 8'h00);
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    chk("postrst_err", {7'd0, err}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
